// File: rtl/ps2_mouse_cmd_responder_if.sv
// Byte link between the PS/2 device receiver/transmitter pair and the mouse command responder.
// The master side owns the serial engines; the slave side is the responder.
interface ps2_mouse_cmd_responder_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       tx_done_tick;
    logic       wr_ps2;
    logic [7:0] tx_data;

    modport master (
        output rx_done_tick,
        output rx_data,
        output tx_done_tick,
        input  wr_ps2,
        input  tx_data
    );

    modport slave (
        input  rx_done_tick,
        input  rx_data,
        input  tx_done_tick,
        output wr_ps2,
        output tx_data
    );
endinterface

// File: rtl/ps2_mouse_cmd_responder.sv
// Device-side PS/2 mouse command responder: decodes host commands, acks them, holds mouse config.
// Define PS2_MOUSE_RESET_CMD_EN to handle host byte FF as the reset command (FA, AA, 00).
module ps2_mouse_cmd_responder (
    input  logic       clk,
    input  logic       rst,
    ps2_mouse_cmd_responder_if.slave link,
    output logic [1:0] resolution,
    output logic [7:0] sample_rate,
    output logic       scaling_2to1,
    output logic       reporting_en,
    output logic       rx_overrun
);
    localparam logic [7:0] RESP_ACK = 8'hFA;
    localparam logic [7:0] RESP_ERR = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        ACK_WAIT,
        PARAM_WAIT,
        PARAM_ACK_WAIT
`ifdef PS2_MOUSE_RESET_CMD_EN
        ,
        BAT_SEND,
        BAT_WAIT,
        ID_SEND,
        ID_WAIT
`endif
    } state_t;

    state_t     state_reg;
    state_t     ret_state_reg;
    logic       pending_rate_reg;
    logic       wr_ps2_reg;
    logic [7:0] tx_data_reg;
    logic [1:0] resolution_reg;
    logic [7:0] sample_rate_reg;
    logic       scaling_reg;
    logic       reporting_reg;
    logic       rx_overrun_reg;
    logic       busy;

    function automatic logic rate_valid(input logic [7:0] b);
        case (b)
            8'd10, 8'd20, 8'd40, 8'd60, 8'd80, 8'd100, 8'd200: rate_valid = 1'b1;
            default:                                          rate_valid = 1'b0;
        endcase
    endfunction

    // Only IDLE and PARAM_WAIT consume host bytes; everywhere else a byte is lost.
    assign busy = (state_reg != IDLE) && (state_reg != PARAM_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            ret_state_reg    <= IDLE;
            pending_rate_reg <= 1'b0;
            wr_ps2_reg       <= 1'b0;
            tx_data_reg      <= 8'h00;
            resolution_reg   <= 2'd2;
            sample_rate_reg  <= 8'd100;
            scaling_reg      <= 1'b0;
            reporting_reg    <= 1'b0;
            rx_overrun_reg   <= 1'b0;
        end else begin
            wr_ps2_reg     <= 1'b0;
            rx_overrun_reg <= link.rx_done_tick && busy;
            case (state_reg)
                IDLE: begin
                    if (link.rx_done_tick) begin
                        wr_ps2_reg    <= 1'b1;
                        tx_data_reg   <= RESP_ACK;
                        state_reg     <= ACK_WAIT;
                        ret_state_reg <= IDLE;
                        case (link.rx_data)
                            8'hE8: begin
                                pending_rate_reg <= 1'b0;
                                ret_state_reg    <= PARAM_WAIT;
                            end
                            8'hF3: begin
                                pending_rate_reg <= 1'b1;
                                ret_state_reg    <= PARAM_WAIT;
                            end
                            8'hE6: scaling_reg   <= 1'b0;
                            8'hE7: scaling_reg   <= 1'b1;
                            8'hF4: reporting_reg <= 1'b1;
                            8'hF5: reporting_reg <= 1'b0;
`ifdef PS2_MOUSE_RESET_CMD_EN
                            8'hFF: begin
                                resolution_reg  <= 2'd2;
                                sample_rate_reg <= 8'd100;
                                scaling_reg     <= 1'b0;
                                reporting_reg   <= 1'b0;
                                ret_state_reg   <= BAT_SEND;
                            end
`endif
                            default: tx_data_reg <= RESP_ERR;
                        endcase
                    end
                end
                PARAM_WAIT: begin
                    if (link.rx_done_tick) begin
                        wr_ps2_reg <= 1'b1;
                        state_reg  <= PARAM_ACK_WAIT;
                        if (pending_rate_reg) begin
                            if (rate_valid(link.rx_data)) begin
                                sample_rate_reg <= link.rx_data;
                                tx_data_reg     <= RESP_ACK;
                            end else begin
                                tx_data_reg <= RESP_ERR;
                            end
                        end else if (link.rx_data <= 8'd3) begin
                            resolution_reg <= link.rx_data[1:0];
                            tx_data_reg    <= RESP_ACK;
                        end else begin
                            tx_data_reg <= RESP_ERR;
                        end
                    end
                end
                ACK_WAIT: begin
                    if (link.tx_done_tick) begin
                        state_reg <= ret_state_reg;
`ifdef PS2_MOUSE_RESET_CMD_EN
                        // BAT completion code goes out on the cycle right after the FA finishes.
                        if (ret_state_reg == BAT_SEND) begin
                            wr_ps2_reg  <= 1'b1;
                            tx_data_reg <= 8'hAA;
                        end
`endif
                    end
                end
                PARAM_ACK_WAIT: begin
                    if (link.tx_done_tick) begin
                        state_reg <= IDLE;
                    end
                end
`ifdef PS2_MOUSE_RESET_CMD_EN
                BAT_SEND: state_reg <= BAT_WAIT;
                BAT_WAIT: begin
                    if (link.tx_done_tick) begin
                        wr_ps2_reg  <= 1'b1;
                        tx_data_reg <= 8'h00;
                        state_reg   <= ID_SEND;
                    end
                end
                ID_SEND: state_reg <= ID_WAIT;
                ID_WAIT: begin
                    if (link.tx_done_tick) begin
                        state_reg <= IDLE;
                    end
                end
`endif
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign link.wr_ps2  = wr_ps2_reg;
    assign link.tx_data = tx_data_reg;
    assign resolution   = resolution_reg;
    assign sample_rate  = sample_rate_reg;
    assign scaling_2to1 = scaling_reg;
    assign reporting_en = reporting_reg;
    assign rx_overrun   = rx_overrun_reg;
endmodule

// File: doc/ps2_mouse_cmd_responder.md
# ps2_mouse_cmd_responder

Device-side PS/2 mouse command responder: the mouse end of the host initialization sequence. It sits between a PS/2 device byte receiver and transmitter. It decodes host command bytes, acknowledges them, consumes parameter bytes, and holds the resulting mouse configuration for the packet generator. It is used both as a bench mouse model and as the control core of a mouse emulator.

## Interface
- No parameters.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-high
- rx_done_tick  in  1  one-cycle pulse: rx_data holds a complete host byte
- rx_data  in  8  received host byte, valid only with rx_done_tick
- tx_done_tick  in  1  one-cycle pulse: transmitter finished the current byte
- wr_ps2  out  1  one-cycle pulse: start transmitting tx_data
- tx_data  out  8  registered response byte, stable from wr_ps2 until tx_done_tick
- resolution  out  2  resolution code; reset 2'd2
- sample_rate  out  8  samples/s; reset 8'd100
- scaling_2to1  out  1  1 = 2:1 scaling; reset 0
- reporting_en  out  1  stream reporting enabled; reset 0
- rx_overrun  out  1  one-cycle pulse: a host byte was dropped while busy

## Operation
- Response codes: ACK 8'hFA; error 8'hFE.
- States: IDLE, ACK_WAIT, PARAM_WAIT, PARAM_ACK_WAIT, and with the macro BAT_SEND, BAT_WAIT, ID_SEND, ID_WAIT.
- IDLE, when rx_done_tick arrives, decodes rx_data:
  - E8 or F3: send FA. Latch the pending command. Go ACK_WAIT, then PARAM_WAIT.
  - E6: clear scaling_2to1, send FA, go ACK_WAIT, then IDLE.
  - E7: set scaling_2to1, send FA, go ACK_WAIT, then IDLE.
  - F4: set reporting_en, send FA, go ACK_WAIT, then IDLE.
  - F5: clear reporting_en, send FA, go ACK_WAIT, then IDLE.
  - Any other byte: send FE, go ACK_WAIT, then IDLE. No configuration change.
- Configuration outputs update in the same cycle that wr_ps2 pulses.
- PARAM_WAIT: the next received byte is always treated as the parameter, never decoded as a command.
  - Pending E8, byte ≤ 3: resolution ← byte[1:0], send FA.
  - Pending E8, byte > 3: send FE, resolution unchanged.
  - Pending F3, byte in {10,20,40,60,80,100,200}: sample_rate ← byte, send FA.
  - Pending F3, any other byte: send FE, sample_rate unchanged.
  - In every case go PARAM_ACK_WAIT, then IDLE on tx_done_tick.
- WAIT states leave only on tx_done_tick. tx_done_tick in IDLE or PARAM_WAIT is ignored.
- rx_done_tick in any WAIT or SEND state: the byte is discarded and rx_overrun pulses for 1 cycle; state and outputs are unchanged.

## Timing
- rx_done_tick in cycle N → wr_ps2 high in cycle N+1 for exactly 1 cycle. tx_data is valid in cycle N+1.
- tx_done_tick in cycle M → the FSM is in its next state at cycle M+1. It accepts a new rx_done_tick from cycle M+1 onward.
- rx_done_tick and tx_done_tick in the same cycle in a WAIT state: the transition is taken and the byte is dropped with rx_overrun.
- Reset values: wr_ps2=0, tx_data=8'h00, rx_overrun=0, state IDLE, configuration outputs as listed in Interface.
- rst asserted mid-transaction: all outputs take reset values at the next edge. The pending command is discarded and no further wr_ps2 is issued.

## Configuration
- Macro: PS2_MOUSE_RESET_CMD_EN.
- Defined: host byte FF is handled as the reset command.
  - Send FA, then BAT_SEND; send AA on the cycle after the FA tx_done_tick; then BAT_WAIT.
  - ID_SEND: send 00 on the cycle after the AA tx_done_tick; then ID_WAIT, then IDLE.
  - Configuration outputs return to reset values when the FA wr_ps2 pulses.
- Undefined: FF is an unknown command. Respond FE; no state change beyond the ACK_WAIT round trip.

## Test plan
- Resolution command: E8 → FA; tx_done; 03 → FA; resolution=3.
- Resolution error: then E8 → FA; 07 → FE; resolution stays 3.
- Sample rate: F3 → FA; 28 → FA; sample_rate=40. Then F3, 2A → FE; sample_rate stays 40.
- Simple commands: E7 → scaling_2to1=1. F4 → reporting_en=1. 55 → FE with no output change.
- Overrun: E6 sent, second byte during ACK_WAIT → rx_overrun pulses once, one FA only. A same-cycle tx_done_tick/rx_done_tick pair also drops the byte with rx_overrun.
- Reset-command and rst behaviour:
  - With PS2_MOUSE_RESET_CMD_EN: after prior configuration, FF → FA, AA, 00 in order, each after the prior tx_done_tick; outputs at defaults.
  - Without the macro: FF → FE.
  - rst asserted in PARAM_WAIT returns the block to defaults with no further wr_ps2.
